adder_bist_ctrl: RTL and testbench

Sequential self-test driver/checker for the 32-bit ripple/CLA adder family (a, b, Cin -> sum, Cout, of). It generates operands from a corner-case table followed by LFSR vectors and drives them onto an adder under test. It compares the returned sum, carry and (optionally) overflow against an internal reference and reports pass/fail and an error count. It sits beside any adder variant as an on-chip BIST wrapper.

---
 rtl/adder_bist_pkg.sv | 34 +++
 rtl/adder_bist_lfsr.sv | 28 ++
 rtl/adder_bist_ctrl.sv | 174 +++++++++++++++++
 tb/tb_adder_bist_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared constants, state codes and corner vectors for the adder BIST
package adder_bist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DRIVE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [15:0] ERR_SAT   = 16'hFFFF;
  localparam logic [15:0] NO_FAIL   = 16'hFFFF;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } corner_t;

  // Carry, overflow and all-ones corners exercised before the pseudo-random phase
  function automatic corner_t corner_vec(input logic [1:0] idx);
    corner_t v;
    case (idx)
      2'd0:    v = '{a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, cin: 1'b0};
      2'd1:    v = '{a: 32'h8FFFFFFF, b: 32'h8FFFFFFF, cin: 1'b0};
      2'd2:    v = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, cin: 1'b0};
      default: v = '{a: 32'h00000000, b: 32'hFFFFFFFF, cin: 1'b1};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// rtl/adder_bist_lfsr.sv - right-shifting Galois LFSR operand source with seed reload
module adder_bist_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] MASK  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= SEED;
    end else if (load) begin
      r_value <= SEED;
    end else if (step) begin
      r_value <= (r_value >> 1) ^ (r_value[0] ? MASK : '0);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - BIST driver/checker for a WIDTH-bit adder; overflow checking under ADDER_BIST_OF_CHECK_EN
import adder_bist_pkg::*;

module adder_bist_ctrl #(
  parameter int          WIDTH         = 32,
  parameter int          NUM_VECTORS   = 64,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED_A        = 32'hACE12468,
  parameter logic [31:0] SEED_B        = 32'h13579BDF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             cin_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             cout_i,
  input  logic             of_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_idx,
  output logic [15:0]      first_fail_idx
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] SETTLE   = 16'(SETTLE_CYCLES);

  state_t           r_state;
  logic [15:0]      r_wait;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err;
  logic [15:0]      r_vec;
  logic [15:0]      r_first_fail;

  logic             w_start_ok;
  logic             w_lfsr_step;
  logic [WIDTH-1:0] w_lfsr_a;
  logic [WIDTH-1:0] w_lfsr_b;
  corner_t          w_corner;
  logic [WIDTH:0]   w_exp;
  logic [WIDTH-1:0] w_exp_sum;
  logic             w_exp_cout;
  logic             w_mismatch;
  logic [15:0]      w_err_next;

  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_lfsr_step = (r_state == ST_DRIVE) && (r_vec >= 16'd4);
  assign w_corner    = corner_vec(r_vec[1:0]);

  adder_bist_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (WIDTH'(SEED_A)),
    .MASK  (WIDTH'(LFSR_MASK))
  ) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_start_ok),
    .step  (w_lfsr_step),
    .value (w_lfsr_a)
  );

  adder_bist_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (WIDTH'(SEED_B)),
    .MASK  (WIDTH'(LFSR_MASK))
  ) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_start_ok),
    .step  (w_lfsr_step),
    .value (w_lfsr_b)
  );

  // Reference is taken from the registered operands, which hold from DRIVE through CHECK
  assign w_exp      = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_exp_sum  = w_exp[WIDTH-1:0];
  assign w_exp_cout = w_exp[WIDTH];

`ifdef ADDER_BIST_OF_CHECK_EN
  logic w_exp_of;
  assign w_exp_of   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_exp_sum[WIDTH-1] != r_a[WIDTH-1]);
  assign w_mismatch = (sum_i != w_exp_sum) || (cout_i != w_exp_cout) || (of_i != w_exp_of);
`else
  logic w_unused_of;
  assign w_unused_of = of_i;
  assign w_mismatch  = (sum_i != w_exp_sum) || (cout_i != w_exp_cout);
`endif

  assign w_err_next = (w_mismatch && (r_err != ERR_SAT)) ? r_err + 16'd1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wait       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_vec        <= '0;
      r_first_fail <= NO_FAIL;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_err        <= '0;
            r_vec        <= '0;
            r_first_fail <= NO_FAIL;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_vec < 16'd4) begin
            r_a   <= WIDTH'(w_corner.a);
            r_b   <= WIDTH'(w_corner.b);
            r_cin <= w_corner.cin;
          end else begin
            r_a   <= w_lfsr_a;
            r_b   <= w_lfsr_b;
            r_cin <= w_lfsr_a[0] ^ w_lfsr_b[0];
          end
          r_wait  <= SETTLE;
          r_state <= (SETTLE == 16'd0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          r_wait <= r_wait - 16'd1;
          if (r_wait == 16'd1) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && (r_first_fail == NO_FAIL)) begin
            r_first_fail <= r_vec;
          end
          if (r_vec == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 16'd0);
            r_state <= ST_DONE;
          end else begin
            r_vec   <= r_vec + 16'd1;
            r_state <= ST_DRIVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_o            = r_a;
  assign b_o            = r_b;
  assign cin_o          = r_cin;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign vec_idx        = r_vec;
  assign first_fail_idx = r_first_fail;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb/tb_adder_bist_ctrl.sv - self-checking bench for adder_bist_ctrl with a behavioural adder and reference model
module tb_adder_bist_ctrl;

  localparam int N0 = 16;
  localparam int S0 = 2;
  localparam int N1 = 4;
  localparam int S1 = 0;
  localparam logic [31:0] SA   = 32'hACE12468;
  localparam logic [31:0] SB   = 32'h13579BDF;
  localparam logic [31:0] MASK = 32'h80200003;

  localparam int M_GOLD  = 0;
  localparam int M_COUT0 = 1;
  localparam int M_OF0   = 2;
  localparam int M_SUMX  = 3;
  localparam int M_RAND  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] a0, b0, sum0, a1, b1, sum1;
  logic        cin0, cout0, of0, cin1, cout1, of1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, vec0, ff0, err1, vec1, ff1;
  int          mode0 = M_GOLD;
  int          mode1 = M_GOLD;
  logic [63:0] fmask0 = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ea [64];
  logic [31:0] eb [64];
  logic        ec [64];
  int          exp_err;
  logic [15:0] exp_ff;

  always #5 clk = ~clk;

  // Behavioural adder with selectable faults; returns {of, cout, sum}
  function automatic logic [33:0] adder_resp(input logic [31:0] a, input logic [31:0] b,
                                             input logic cin, input int mode, input logic faulty);
    logic [32:0] s;
    logic        of;
    s  = {1'b0, a} + {1'b0, b} + 33'(cin);
    of = (a[31] == b[31]) && (s[31] != a[31]);
    case (mode)
      M_COUT0: s[32] = 1'b0;
      M_OF0:   of = 1'b0;
      M_SUMX:  s[0] = ~s[0];
      M_RAND:  if (faulty) s[0] = ~s[0];
      default: ;
    endcase
    return {of, s};
  endfunction

  always_comb {of0, cout0, sum0} = adder_resp(a0, b0, cin0, mode0, fmask0[vec0[5:0]]);
  always_comb {of1, cout1, sum1} = adder_resp(a1, b1, cin1, mode1, 1'b0);

  adder_bist_ctrl #(.WIDTH(32), .NUM_VECTORS(N0), .SETTLE_CYCLES(S0), .SEED_A(SA), .SEED_B(SB)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .a_o(a0), .b_o(b0), .cin_o(cin0),
    .sum_i(sum0), .cout_i(cout0), .of_i(of0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .vec_idx(vec0), .first_fail_idx(ff0)
  );

  adder_bist_ctrl #(.WIDTH(32), .NUM_VECTORS(N1), .SETTLE_CYCLES(S1), .SEED_A(SA), .SEED_B(SB)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a_o(a1), .b_o(b1), .cin_o(cin1),
    .sum_i(sum1), .cout_i(cout1), .of_i(of1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_idx(vec1), .first_fail_idx(ff1)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operand list and expected verdict derived from the corner table, LFSR rule and adder arithmetic
  task automatic build_model(input int n, input int mode, input logic [63:0] fm);
    logic [31:0] la, lb;
    logic [33:0] gold, got;
    logic        bad;
    la      = SA;
    lb      = SB;
    exp_err = 0;
    exp_ff  = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      case (k)
        0: begin ea[k] = 32'h7FFFFFFF; eb[k] = 32'h7FFFFFFF; ec[k] = 1'b0; end
        1: begin ea[k] = 32'h8FFFFFFF; eb[k] = 32'h8FFFFFFF; ec[k] = 1'b0; end
        2: begin ea[k] = 32'hFFFFFFFF; eb[k] = 32'hFFFFFFFF; ec[k] = 1'b0; end
        3: begin ea[k] = 32'h00000000; eb[k] = 32'hFFFFFFFF; ec[k] = 1'b1; end
        default: begin
          ea[k] = la;
          eb[k] = lb;
          ec[k] = la[0] ^ lb[0];
          la = (la >> 1) ^ (la[0] ? MASK : 32'h0);
          lb = (lb >> 1) ^ (lb[0] ? MASK : 32'h0);
        end
      endcase
      gold = adder_resp(ea[k], eb[k], ec[k], M_GOLD, 1'b0);
      got  = adder_resp(ea[k], eb[k], ec[k], mode, fm[k]);
      bad  = (got[32:0] != gold[32:0]);
`ifdef ADDER_BIST_OF_CHECK_EN
      bad = bad || (got[33] != gold[33]);
`endif
      if (bad) begin
        exp_err++;
        if (exp_ff == 16'hFFFF) exp_ff = 16'(k);
      end
    end
  endtask

  task automatic run0(input int mode, input logic [63:0] fm, input int mid_start);
    int   busy_cnt;
    int   p_idx;
    logic [64:0] p_ops;
    logic have_p;
    logic fin;
    mode0  = mode;
    fmask0 = fm;
    build_model(N0, mode, fm);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    busy_cnt = 0;
    p_idx    = 0;
    p_ops    = '0;
    have_p   = 1'b0;
    fin      = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      start0 = (c == mid_start);
      if (have_p && ((vec0 != 16'(p_idx)) || done0))
        check($sformatf("ops[%0d]", p_idx), 72'(p_ops), 72'({ea[p_idx], eb[p_idx], ec[p_idx]}));
      if (busy0) begin
        busy_cnt++;
        p_idx  = int'(vec0);
        p_ops  = {a0, b0, cin0};
        have_p = 1'b1;
      end
      if (done0) fin = 1'b1;
    end
    start0 = 1'b0;
    check("done0", 72'(done0), 72'(1));
    check("busy_cycles0", 72'(busy_cnt), 72'(N0 * (S0 + 2)));
    check("err0", 72'(err0), 72'(exp_err));
    check("first_fail0", 72'(ff0), 72'(exp_ff));
    check("pass0", 72'(pass0), 72'(exp_err == 0));
  endtask

  task automatic run1(input int mode);
    int   busy_cnt;
    logic fin;
    mode1 = mode;
    build_model(N1, mode, 64'h0);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    busy_cnt = 0;
    fin      = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      @(negedge clk);
      if (busy1) busy_cnt++;
      if (done1) fin = 1'b1;
    end
    check("done1", 72'(done1), 72'(1));
    check("busy_cycles1", 72'(busy_cnt), 72'(8));
    check("err1", 72'(err1), 72'(exp_err));
    check("first_fail1", 72'(ff1), 72'(exp_ff));
    check("pass1", 72'(pass1), 72'(exp_err == 0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_ops", 72'({a0, b0, cin0}), 72'(0));
    check("rst_flags", 72'({busy0, done0, pass0}), 72'(0));
    check("rst_err", 72'(err0), 72'(0));
    check("rst_vec", 72'(vec0), 72'(0));
    check("rst_ff", 72'(ff0), 72'(16'hFFFF));
    @(negedge clk);
    rst_n = 1'b1;

    run0(M_GOLD, 64'h0, -1);
    run0(M_COUT0, 64'h0, -1);
    check("cout0_first_fail", 72'(ff0), 72'(1));
    run0(M_OF0, 64'h0, -1);

    mode0 = M_GOLD;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (21) @(posedge clk);
    #2;
    check("abort_at_vec", 72'(vec0), 72'(5));
    check("abort_busy", 72'(busy0), 72'(1));
    rst_n = 1'b0;
    #1;
    check("abort_ops", 72'({a0, b0, cin0}), 72'(0));
    check("abort_flags", 72'({busy0, done0, pass0, err0, vec0}), 72'(0));
    check("abort_ff", 72'(ff0), 72'(16'hFFFF));
    @(negedge clk);
    rst_n = 1'b1;
    run0(M_GOLD, 64'h0, -1);

    run0(M_GOLD, 64'h0, 10);
    run0(M_GOLD, 64'h0, -1);

    for (int i = 0; i < 4; i++)
      run0(M_RAND, {$urandom, $urandom}, int'($urandom_range(3, 50)));

    run1(M_SUMX);
    run1(M_GOLD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
